rs_age_sched: RTL

//  Parametrised reservation station with NUM_CDB wakeup channels and oldest-first select.

---
 rtl/rs_age_sched_pkg.sv | 13 +
 rtl/rs_age_sched_if.sv | 57 +++++
 rtl/rs_age_matrix.sv | 47 ++++
 rtl/rs_age_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_sched_pkg.sv
// Shared types for the age-ordered reservation station and its bench.
package rs_age_sched_pkg;

    localparam int unsigned ROB_W = 4;

    // Issued operation type: [4] branch, [3] inst[30], [2:0] funct3
    typedef struct packed {
        logic       branch;
        logic       alt;
        logic [2:0] funct3;
    } op_t;

endpackage

// File: rtl/rs_age_sched_if.sv
// Dispatch, CDB wakeup and issue bundle between decoder, RS and execution unit.
interface rs_age_sched_if
    import rs_age_sched_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned XLEN     = 32
) ();
    localparam int unsigned RS_IDX_W = $clog2(RS_DEPTH);

    logic                     rs_full;
    logic [RS_IDX_W:0]        rs_count;

    logic                     disp_valid;
    op_t                      disp_type;
    logic [XLEN-1:0]          disp_vj;
    logic [XLEN-1:0]          disp_vk;
    logic                     disp_dj;
    logic                     disp_dk;
    logic [ROB_W-1:0]         disp_qj;
    logic [ROB_W-1:0]         disp_qk;
    logic [ROB_W-1:0]         disp_rob_id;
    logic [XLEN-1:0]          disp_tja;
    logic [XLEN-1:0]          disp_fja;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;

    logic                     iss_valid;
    logic                     iss_ready;
    op_t                      iss_op;
    logic [XLEN-1:0]          iss_lhs;
    logic [XLEN-1:0]          iss_rhs;
    logic [ROB_W-1:0]         iss_rob_id;
    logic [XLEN-1:0]          iss_tja;
    logic [XLEN-1:0]          iss_fja;

    modport master (
        input  rs_full, rs_count,
        output disp_valid, disp_type, disp_vj, disp_vk, disp_dj, disp_dk,
        output disp_qj, disp_qk, disp_rob_id, disp_tja, disp_fja,
        output cdb_valid, cdb_rob_id, cdb_value,
        input  iss_valid, iss_op, iss_lhs, iss_rhs, iss_rob_id, iss_tja, iss_fja,
        output iss_ready
    );

    modport slave (
        output rs_full, rs_count,
        input  disp_valid, disp_type, disp_vj, disp_vk, disp_dj, disp_dk,
        input  disp_qj, disp_qk, disp_rob_id, disp_tja, disp_fja,
        input  cdb_valid, cdb_rob_id, cdb_value,
        output iss_valid, iss_op, iss_lhs, iss_rhs, iss_rob_id, iss_tja, iss_fja,
        input  iss_ready
    );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative entry age and grants the oldest requester.
// older_q[k][j] = 1 means entry j is older than entry k.
module rs_age_matrix #(
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] live,
    input  logic [RS_DEPTH-1:0] alloc_oh,
    input  logic [RS_DEPTH-1:0] free_oh,
    input  logic [RS_DEPTH-1:0] req,
    output logic [RS_DEPTH-1:0] grant_c
);
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];

    // A requester wins when no other requester is older than it.
    always_comb begin
        grant_c = '0;
        for (int unsigned k = 0; k < RS_DEPTH; k++) begin
            grant_c[k] = req[k] && ((older_q[k] & req) == '0);
        end
    end

    // New entry's row lists every surviving entry; a freed entry's column is cleared.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned k = 0; k < RS_DEPTH; k++) begin
                older_q[k] <= '0;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < RS_DEPTH; k++) begin
                for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                    if (flush) begin
                        older_q[k][j] <= 1'b0;
                    end else if (alloc_oh[k]) begin
                        older_q[k][j] <= live[j] & ~free_oh[j];
                    end else if (free_oh[j] || alloc_oh[j]) begin
                        older_q[k][j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rs_age_sched.sv
// Reservation station with multi-channel CDB wakeup and oldest-first issue.
module rs_age_sched
    import rs_age_sched_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned XLEN     = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear,
    rs_age_sched_if.slave bus
);
    localparam int unsigned RS_IDX_W = $clog2(RS_DEPTH);
    localparam int unsigned CNT_W    = RS_IDX_W + 1;

    logic [RS_DEPTH-1:0] busy_q, dj_q, dk_q;
    logic [XLEN-1:0]     vj_q [RS_DEPTH];
    logic [XLEN-1:0]     vk_q [RS_DEPTH];
    logic [XLEN-1:0]     tja_q [RS_DEPTH];
    logic [XLEN-1:0]     fja_q [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q [RS_DEPTH];
    op_t                 op_q [RS_DEPTH];
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q;

    logic                iss_valid_q;
    op_t                 iss_op_q, sel_op;
    logic [XLEN-1:0]     iss_lhs_q, iss_rhs_q, iss_tja_q, iss_fja_q;
    logic [XLEN-1:0]     sel_lhs, sel_rhs, sel_tja, sel_fja;
    logic [ROB_W-1:0]    iss_rob_q, sel_rob;

    logic [RS_DEPTH-1:0] wj_hit, wk_hit;
    logic [XLEN-1:0]     wj_val [RS_DEPTH];
    logic [XLEN-1:0]     wk_val [RS_DEPTH];
    logic                bj_hit, bk_hit;
    logic [XLEN-1:0]     bj_val, bk_val;
    logic [RS_DEPTH-1:0] cand, grant_c, alloc_oh, free_oh;
    logic                adv, fire;

    // Tag match against every channel; the lowest matching channel supplies the value.
    always_comb begin
        bj_hit = 1'b0;
        bk_hit = 1'b0;
        bj_val = '0;
        bk_val = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            wj_hit[i] = 1'b0;
            wk_hit[i] = 1'b0;
            wj_val[i] = '0;
            wk_val[i] = '0;
        end
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            if (bus.cdb_valid[c]) begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    if (!wj_hit[i] && bus.cdb_rob_id[c*ROB_W +: ROB_W] == qj_q[i]) begin
                        wj_hit[i] = 1'b1;
                        wj_val[i] = bus.cdb_value[c*XLEN +: XLEN];
                    end
                    if (!wk_hit[i] && bus.cdb_rob_id[c*ROB_W +: ROB_W] == qk_q[i]) begin
                        wk_hit[i] = 1'b1;
                        wk_val[i] = bus.cdb_value[c*XLEN +: XLEN];
                    end
                end
                if (!bj_hit && bus.cdb_rob_id[c*ROB_W +: ROB_W] == bus.disp_qj) begin
                    bj_hit = 1'b1;
                    bj_val = bus.cdb_value[c*XLEN +: XLEN];
                end
                if (!bk_hit && bus.cdb_rob_id[c*ROB_W +: ROB_W] == bus.disp_qk) begin
                    bk_hit = 1'b1;
                    bk_val = bus.cdb_value[c*XLEN +: XLEN];
                end
            end
        end
    end

    // Lowest free index takes the dispatch; requests while full are dropped.
    always_comb begin
        alloc_oh = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!busy_q[i] && alloc_oh == '0) begin
                alloc_oh[i] = 1'b1;
            end
        end
        if (!bus.disp_valid || full_q) begin
            alloc_oh = '0;
        end
    end

    assign cand    = busy_q & ~dj_q & ~dk_q;
    assign adv     = !iss_valid_q || bus.iss_ready;
    assign fire    = adv && (cand != '0);
    assign free_oh = fire ? grant_c : '0;
    assign count_d = count_q + CNT_W'(alloc_oh != '0) - CNT_W'(fire);

    rs_age_matrix #(.RS_DEPTH(RS_DEPTH)) u_age (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (rdy_in),
        .flush    (clear),
        .live     (busy_q),
        .alloc_oh (alloc_oh),
        .free_oh  (free_oh),
        .req      (cand),
        .grant_c  (grant_c)
    );

    always_comb begin
        sel_op  = '0;
        sel_lhs = '0;
        sel_rhs = '0;
        sel_rob = '0;
        sel_tja = '0;
        sel_fja = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (grant_c[i]) begin
                sel_op  = op_q[i];
                sel_lhs = vj_q[i];
                sel_rhs = vk_q[i];
                sel_rob = rob_q[i];
                sel_tja = tja_q[i];
                sel_fja = fja_q[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            dj_q        <= '0;
            dk_q        <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_lhs_q   <= '0;
            iss_rhs_q   <= '0;
            iss_rob_q   <= '0;
            iss_tja_q   <= '0;
            iss_fja_q   <= '0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                tja_q[i] <= '0;
                fja_q[i] <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                busy_q      <= '0;
                count_q     <= '0;
                full_q      <= 1'b0;
                iss_valid_q <= 1'b0;
            end else begin
                busy_q  <= (busy_q & ~free_oh) | alloc_oh;
                count_q <= count_d;
                full_q  <= (count_d == CNT_W'(RS_DEPTH));
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    if (alloc_oh[i]) begin
                        op_q[i]  <= bus.disp_type;
                        rob_q[i] <= bus.disp_rob_id;
                        tja_q[i] <= bus.disp_tja;
                        fja_q[i] <= bus.disp_fja;
                        qj_q[i]  <= bus.disp_qj;
                        qk_q[i]  <= bus.disp_qk;
                        dj_q[i]  <= bus.disp_dj && !bj_hit;
                        dk_q[i]  <= bus.disp_dk && !bk_hit;
                        vj_q[i]  <= (bus.disp_dj && bj_hit) ? bj_val : bus.disp_vj;
                        vk_q[i]  <= (bus.disp_dk && bk_hit) ? bk_val : bus.disp_vk;
                    end else if (busy_q[i]) begin
                        if (dj_q[i] && wj_hit[i]) begin
                            vj_q[i] <= wj_val[i];
                            dj_q[i] <= 1'b0;
                        end
                        if (dk_q[i] && wk_hit[i]) begin
                            vk_q[i] <= wk_val[i];
                            dk_q[i] <= 1'b0;
                        end
                    end
                end
                if (adv) begin
                    iss_valid_q <= fire;
                    if (fire) begin
                        iss_op_q  <= sel_op;
                        iss_lhs_q <= sel_lhs;
                        iss_rhs_q <= sel_rhs;
                        iss_rob_q <= sel_rob;
                        iss_tja_q <= sel_tja;
                        iss_fja_q <= sel_fja;
                    end
                end
            end
        end
    end

    assign bus.rs_full    = full_q;
    assign bus.rs_count   = count_q;
    assign bus.iss_valid  = iss_valid_q;
    assign bus.iss_op     = iss_op_q;
    assign bus.iss_lhs    = iss_lhs_q;
    assign bus.iss_rhs    = iss_rhs_q;
    assign bus.iss_rob_id = iss_rob_q;
    assign bus.iss_tja    = iss_tja_q;
    assign bus.iss_fja    = iss_fja_q;

endmodule
